// File: rtl/data_mem_unit.sv
// Word-addressed 32-bit data memory serving the CPU load/store port.
// Double-word accesses run over two cycles (A, then A+1); illegal requests raise addr_fault.
module data_mem_unit #(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_data_out,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        ldw_sdw,
    output logic [31:0] mem_data_in,
    output logic        mem_ready,
    output logic        mem_busy,
    output logic        dw_phase,
    output logic        addr_fault
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        IDLE,
        DW2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] base_addr_next;
    logic              dw_is_write;
    logic              dw_is_write_next;

    // Array is deliberately not reset so its contents survive rst.
    logic [31:0]       mem [DEPTH];

    logic [ADDR_W-1:0] word_addr;
    logic [ADDR_W-1:0] second_addr;
    logic              req;
    logic              illegal;

    logic              we;
    logic [ADDR_W-1:0] waddr;

    logic [31:0]       data_next;
    logic              ready_next;
    logic              busy_next;
    logic              phase_next;
    logic              fault_next;

    always_comb begin
        word_addr   = mem_address[ADDR_W-1:0];
        second_addr = base_addr + ADDR_W'(1);
        req         = mem_read | mem_write;
        illegal     = (mem_read & mem_write)
                    | (mem_address[31:ADDR_W] != '0)
                    | (ldw_sdw & mem_address[0])
                    | (ldw_sdw & (word_addr == '1));
    end

    always_comb begin
        state_next       = state;
        base_addr_next   = base_addr;
        dw_is_write_next = dw_is_write;
        data_next        = mem_data_in;
        ready_next       = 1'b0;
        busy_next        = 1'b0;
        phase_next       = 1'b0;
        fault_next       = 1'b0;
        we               = 1'b0;
        waddr            = word_addr;

        case (state)
            IDLE: begin
                if (req) begin
                    if (illegal) begin
                        fault_next = 1'b1;
                        data_next  = 32'd0;
                    end else begin
                        ready_next = 1'b1;
                        if (mem_write) begin
                            we = 1'b1;
                        end else begin
                            data_next = mem[word_addr];
                        end
                        if (ldw_sdw) begin
                            base_addr_next   = word_addr;
                            dw_is_write_next = mem_write;
                            busy_next        = 1'b1;
                            state_next       = DW2;
                        end
                    end
                end
            end
            DW2: begin
                // CPU request lines are ignored here; the second word uses base_addr.
                ready_next = 1'b1;
                phase_next = 1'b1;
                state_next = IDLE;
                if (dw_is_write) begin
                    we    = 1'b1;
                    waddr = second_addr;
                end else begin
                    data_next = mem[second_addr];
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= mem_data_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            base_addr   <= '0;
            dw_is_write <= 1'b0;
        end else begin
            state       <= state_next;
            base_addr   <= base_addr_next;
            dw_is_write <= dw_is_write_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_data_in <= 32'd0;
            mem_ready   <= 1'b0;
            mem_busy    <= 1'b0;
            dw_phase    <= 1'b0;
            addr_fault  <= 1'b0;
        end else begin
            mem_data_in <= data_next;
            mem_ready   <= ready_next;
            mem_busy    <= busy_next;
            dw_phase    <= phase_next;
            addr_fault  <= fault_next;
        end
    end

endmodule

// File: doc/data_mem_unit.md
# data_mem_unit

Word-addressed data memory with controller that serves the CPU's load/store port. It sits directly downstream of the CPU: it consumes `mem_address`, `mem_data_out`, `mem_read`, `mem_write` and `ldw_sdw`, and returns read data on the CPU's `mem_data_in`. Double-word accesses (LDW/SDW) are sequenced internally over two consecutive cycles to word addresses A and A+1. The block flags illegal requests instead of performing them.

## Interface
- `ADDR_W`, default 8: word-address width; depth is 2^ADDR_W words of 32 bits.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mem_address` in 32: word address from the CPU.
- `mem_data_out` in 32: store data from the CPU.
- `mem_read` in 1: load request.
- `mem_write` in 1: store request.
- `ldw_sdw` in 1: qualifies the request as double-word.
- `mem_data_in` out 32: registered read data to the CPU.
- `mem_ready` out 1: one-cycle pulse meaning the access completed; for loads, `mem_data_in` is valid in this cycle.
- `mem_busy` out 1: high while the second word of a double-word access is pending.
- `dw_phase` out 1: 0 = first or only word, 1 = second word; qualifies `mem_ready`.
- `addr_fault` out 1: one-cycle pulse marking a rejected request.

## Operation
- **State:** FSM with states IDLE and DW2, plus registers `base_addr[ADDR_W-1:0]` and `dw_is_write`. The memory array has no reset, and its contents survive `rst`.
- **Legality check.** A request is sampled in IDLE when `mem_read|mem_write` is high. It is rejected when any of the following holds:
  - `mem_read&mem_write` are both high;
  - `mem_address[31:ADDR_W]` is not zero;
  - `ldw_sdw` is high and `mem_address[0]` is 1 (misaligned double-word);
  - `ldw_sdw` is high and the address is 2^ADDR_W-1.
- **Rejected request:** `addr_fault`=1 for one cycle. No array write, `mem_data_in` is set to 0, `mem_ready` stays 0, and the state stays IDLE.
- **Single load:** `mem_data_in` <= mem[A]; `mem_ready`=1, `dw_phase`=0; stay in IDLE.
- **Single store:** mem[A] <= `mem_data_out`; `mem_ready`=1; `mem_data_in` holds its value.
- **Double-word, first edge:**
  - Perform the first-word access as above.
  - Latch `base_addr`=A and `dw_is_write`.
  - Assert `mem_busy`=1 and go to DW2.
- **DW2, next edge:**
  - Access word A+1 using `base_addr`, not `mem_address`.
  - For a load, `mem_data_in` <= mem[A+1]. For a store, mem[A+1] <= `mem_data_out` as sampled on this edge, so the CPU presents the second store word in this cycle.
  - Outputs `mem_ready`=1, `dw_phase`=1, `mem_busy`=0; return to IDLE.
- **In DW2:** `mem_read`, `mem_write`, `ldw_sdw` and `mem_address` are ignored, and no new request is accepted. A request still held high in the cycle after return to IDLE is treated as a new request.
- **Idle cycle:** when no request is present in IDLE, `mem_ready`, `dw_phase` and `addr_fault` are 0 and `mem_data_in` holds.
- **Reset:** `rst` asserted at any time, including in DW2, forces IDLE immediately.
  - All outputs go to 0: `mem_data_in`=0, `mem_ready`=0, `mem_busy`=0, `dw_phase`=0, `addr_fault`=0.
  - `base_addr` and `dw_is_write` clear.
  - An interrupted SDW leaves word A written and word A+1 unwritten.

## Timing
- **Request to data:** a request is presented in cycle N and sampled on the edge ending N. Data and `mem_ready` are valid throughout cycle N+1. Latency is 1 cycle.
- **Double-word completion:** `mem_ready` pulses in N+1 (phase 0) and N+2 (phase 1). `mem_busy` is high exactly during cycle N+1.
- **No bypass:** a load from address A in the cycle after a store to A returns the new data. A same-cycle read and write of one address cannot occur because it is rejected.
- **Registered outputs:** all outputs are registered; there is no combinational path from inputs to outputs.
- **Throughput:** one single access per cycle, back-to-back; one double-word access per 2 cycles.

## Test plan
- **Single store then load:** reset, store 0x12345678 to addr 5, then load addr 5 → `mem_data_in`=0x12345678 with `mem_ready`=1, `dw_phase`=0 one cycle after the load request. All outputs are 0 during reset.
- **SDW then LDW:** SDW to addr 4 with `mem_data_out`=0xDEADBEEF, then 0xCAFEF00D in the next cycle. LDW addr 4 → 0xDEADBEEF (phase 0, `mem_busy`=1), then 0xCAFEF00D (phase 1, `mem_busy`=0). During DW2, `mem_address` is driven to 9 and ignored.
- **Illegal requests:**
  - LDW to addr 7 → `addr_fault` pulse, `mem_ready`=0, state stays IDLE.
  - Read of addr 0x100 with `ADDR_W`=8 → fault, `mem_data_in`=0.
  - `mem_read`=`mem_write`=1 → fault and no write (verified by a later load).
- **Reset mid-SDW:** SDW to addr 10 (0x11111111, then 0x22222222), with `rst` asserted asynchronously during DW2 → outputs clear immediately. A subsequent load of addr 10 returns 0x11111111; addr 11 keeps its prior value 0xAAAAAAAA.
- **Back-to-back singles:** loads of addrs 1, 2, 3 in consecutive cycles → data in consecutive cycles, `mem_ready` continuously high, `mem_busy`=0.
